// File: rtl/llc_mem_responder_pkg.sv
// Shared types and constants for the LLC memory-side responder.
package llc_mem_responder_pkg;

    localparam int unsigned LINE_BITS      = 128;
    localparam int unsigned LINE_ADDR_BITS = 32;
    localparam int unsigned HSIZE_BITS     = 3;
    localparam int unsigned LLC_MEM_LINES  = 1024;

    typedef logic [LINE_BITS-1:0]      line_t;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [HSIZE_BITS-1:0]     hsize_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RSP
    } llc_mem_rsp_state_t;

endpackage

// File: rtl/llc_mem_array.sv
// Line storage with per-line written bits; registered read port returns zeros for unwritten lines.
module llc_mem_array
    import llc_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_LINES = LLC_MEM_LINES,
    parameter int unsigned IDX_BITS  = $clog2(MEM_LINES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  line_t               wr_line,
    input  logic                rd_en,
    input  logic [IDX_BITS-1:0] rd_idx,
    output line_t               rd_line
);

    line_t                mem [MEM_LINES];
    logic [MEM_LINES-1:0] written;

    // Contents are deliberately not reset; the written bits mask stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_line;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            written <= '0;
            rd_line <= '0;
        end else begin
            if (wr_en) begin
                written[wr_idx] <= 1'b1;
            end
            if (rd_en) begin
                rd_line <= written[rd_idx] ? mem[rd_idx] : '0;
            end
        end
    end

endmodule

// File: rtl/llc_mem_responder.sv
// LLC memory-channel responder: serialised reads with fixed latency, write-backs into a line array.
// Optional handshake counters enabled by defining LLC_MEM_RSP_STATS_EN.
module llc_mem_responder
    import llc_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_LINES = LLC_MEM_LINES,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        llc_mem_req_valid,
    output logic        llc_mem_req_ready,
    input  logic        llc_mem_req_data_hwrite,
    input  hsize_t      llc_mem_req_data_hsize,
    input  logic [1:0]  llc_mem_req_data_hprot,
    input  line_addr_t  llc_mem_req_data_addr,
    input  line_t       llc_mem_req_data_line,
    output logic        llc_mem_rsp_valid,
    input  logic        llc_mem_rsp_ready,
`ifdef LLC_MEM_RSP_STATS_EN
    output logic [31:0] llc_mem_rd_cnt,
    output logic [31:0] llc_mem_wr_cnt,
`endif
    output line_t       llc_mem_rsp_data_line
);

    localparam int unsigned IDX_BITS = $clog2(MEM_LINES);
    localparam int unsigned CNT_BITS = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    llc_mem_rsp_state_t  state;
    logic [CNT_BITS-1:0] cnt;
    logic                req_hs;
    logic                wr_hs;
    logic                rd_hs;
    logic [IDX_BITS-1:0] idx;
    logic                unused_bits;

    assign req_hs      = llc_mem_req_valid && llc_mem_req_ready;
    assign wr_hs       = req_hs && llc_mem_req_data_hwrite;
    assign rd_hs       = req_hs && !llc_mem_req_data_hwrite;
    assign idx         = llc_mem_req_data_addr[IDX_BITS-1:0];
    assign unused_bits = ^{llc_mem_req_data_hsize, llc_mem_req_data_hprot,
                           llc_mem_req_data_addr[LINE_ADDR_BITS-1:IDX_BITS]};

    // Array is read at acceptance; no writes can land before the response, so the data is final.
    llc_mem_array #(
        .MEM_LINES (MEM_LINES),
        .IDX_BITS  (IDX_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_hs),
        .wr_idx  (idx),
        .wr_line (llc_mem_req_data_line),
        .rd_en   (rd_hs),
        .rd_idx  (idx),
        .rd_line (llc_mem_rsp_data_line)
    );

    // Ready and valid are registered alongside the state they reflect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= '0;
            llc_mem_req_ready <= 1'b0;
            llc_mem_rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    llc_mem_req_ready <= 1'b1;
                    if (rd_hs) begin
                        llc_mem_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state             <= RSP;
                            llc_mem_rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_BITS'(CNT_LOAD);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state             <= RSP;
                        llc_mem_rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_BITS'(1);
                    end
                end
                RSP: begin
                    if (llc_mem_rsp_ready) begin
                        state             <= IDLE;
                        llc_mem_rsp_valid <= 1'b0;
                        llc_mem_req_ready <= 1'b1;
                    end
                end
                default: begin
                    state             <= IDLE;
                    llc_mem_req_ready <= 1'b0;
                    llc_mem_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LLC_MEM_RSP_STATS_EN
    // Saturating handshake counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llc_mem_rd_cnt <= '0;
            llc_mem_wr_cnt <= '0;
        end else begin
            if (rd_hs && (llc_mem_rd_cnt != '1)) begin
                llc_mem_rd_cnt <= llc_mem_rd_cnt + 32'd1;
            end
            if (wr_hs && (llc_mem_wr_cnt != '1)) begin
                llc_mem_wr_cnt <= llc_mem_wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_llc_mem_responder.sv
// Directed self-checking bench for llc_mem_responder (LATENCY=4 and LATENCY=1 instances).
module tb_llc_mem_responder;
    import llc_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_hwrite, rsp_ready;
    line_addr_t  req_addr;
    line_t       req_line;
    logic        req_ready, rsp_valid;
    line_t       rsp_line;
    hsize_t      hsize = '0;
    logic [1:0]  hprot = '0;
`ifdef LLC_MEM_RSP_STATS_EN
    logic [31:0] rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
`endif

    logic        v1, w1, rr1;
    line_addr_t  a1;
    line_t       l1;
    logic        rdy1, rv1;
    line_t       rd1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    llc_mem_responder #(.MEM_LINES(1024), .LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .llc_mem_req_valid(req_valid), .llc_mem_req_ready(req_ready),
        .llc_mem_req_data_hwrite(req_hwrite), .llc_mem_req_data_hsize(hsize),
        .llc_mem_req_data_hprot(hprot), .llc_mem_req_data_addr(req_addr),
        .llc_mem_req_data_line(req_line), .llc_mem_rsp_valid(rsp_valid),
        .llc_mem_rsp_ready(rsp_ready),
`ifdef LLC_MEM_RSP_STATS_EN
        .llc_mem_rd_cnt(rd_cnt), .llc_mem_wr_cnt(wr_cnt),
`endif
        .llc_mem_rsp_data_line(rsp_line)
    );

    llc_mem_responder #(.MEM_LINES(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .llc_mem_req_valid(v1), .llc_mem_req_ready(rdy1),
        .llc_mem_req_data_hwrite(w1), .llc_mem_req_data_hsize(hsize),
        .llc_mem_req_data_hprot(hprot), .llc_mem_req_data_addr(a1),
        .llc_mem_req_data_line(l1), .llc_mem_rsp_valid(rv1),
        .llc_mem_rsp_ready(rr1),
`ifdef LLC_MEM_RSP_STATS_EN
        .llc_mem_rd_cnt(rd_cnt1), .llc_mem_wr_cnt(wr_cnt1),
`endif
        .llc_mem_rsp_data_line(rd1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input line_addr_t addr, input line_t line);
        req_valid = 1'b1; req_hwrite = 1'b1; req_addr = addr; req_line = line;
        step();
        req_valid = 1'b0;
    endtask

    // Issue a read, check latency, data and the ready/valid turnaround.
    task automatic do_read(input string tag, input line_addr_t addr, input line_t exp);
        int n;
        req_valid = 1'b1; req_hwrite = 1'b0; req_addr = addr;
        step();
        req_valid = 1'b0;
        chk({tag, "_ready_low"}, 128'(req_ready), 128'(0));
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(3));
        chk({tag, "_data"}, rsp_line, exp);
        step();
        chk({tag, "_valid_drop"}, 128'(rsp_valid), 128'(0));
        chk({tag, "_ready_back"}, 128'(req_ready), 128'(1));
    endtask

    initial begin
        line_t a5, held;
        a5 = {16{8'hA5}};
        rst = 1'b0; req_valid = 1'b0; req_hwrite = 1'b0; rsp_ready = 1'b1;
        req_addr = '0; req_line = '0;
        v1 = 1'b0; w1 = 1'b0; rr1 = 1'b1; a1 = '0; l1 = '0;

        // Reset values
        step(); step();
        chk("rst_ready", 128'(req_ready), 128'(0));
        chk("rst_valid", 128'(rsp_valid), 128'(0));
        chk("rst_data", rsp_line, 128'(0));
`ifdef LLC_MEM_RSP_STATS_EN
        chk("rst_rdcnt", 128'(rd_cnt), 128'(0));
`endif
        rst = 1'b1;
        step();
        chk("idle_ready", 128'(req_ready), 128'(1));

        // Write then read with latency 4
        do_write(32'h10, a5);
        chk("wr_keeps_ready", 128'(req_ready), 128'(1));
        do_read("rd10", 32'h10, a5);

        // Never-written line reads zero
        do_read("rd3_unwritten", 32'h3, '0);

        // Stall with rsp_ready low for 10 cycles while a write is offered
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_hwrite = 1'b0; req_addr = 32'h10;
        step();
        req_hwrite = 1'b1; req_addr = 32'h10; req_line = '1;
        step(); step(); step();
        chk("stall_rise", 128'(rsp_valid), 128'(1));
        held = rsp_line;
        chk("stall_data0", held, a5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("stall_valid%0d", i), 128'(rsp_valid), 128'(1));
            chk($sformatf("stall_data%0d", i), rsp_line, a5);
            chk($sformatf("stall_ready%0d", i), 128'(req_ready), 128'(0));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("stall_release", 128'(rsp_valid), 128'(0));
        step();
        chk("stall_single", 128'(rsp_valid), 128'(0));
        // The offered write must not have landed
        do_read("stall_nowrite", 32'h10, a5);

        // Back-to-back writes, one per cycle
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("b2b_ready%0d", i), 128'(req_ready), 128'(1));
            req_valid = 1'b1; req_hwrite = 1'b1;
            req_addr = 32'(i); req_line = {16{8'(8'h10 * i)}};
            step();
        end
        req_valid = 1'b0;
        do_read("b2b_rd1", 32'h1, {16{8'h10}});
        do_read("b2b_rd2", 32'h2, {16{8'h20}});
        do_read("b2b_rd3", 32'h3, {16{8'h30}});

        // Aliasing above the index bits
        do_write(32'h005, {4{32'hDEADBEEF}});
        do_read("alias405", 32'h405, {4{32'hDEADBEEF}});

        // Latency 1 instance: valid the cycle after accept
        v1 = 1'b1; w1 = 1'b1; a1 = 32'h005; l1 = {4{32'h1234_5678}};
        step();
        w1 = 1'b0; a1 = 32'h405;
        step();
        v1 = 1'b0;
        chk("lat1_valid", 128'(rv1), 128'(1));
        chk("lat1_data", rd1, {4{32'h1234_5678}});
        chk("lat1_ready", 128'(rdy1), 128'(0));
        step();
        chk("lat1_drop", 128'(rv1), 128'(0));
        chk("lat1_ready_back", 128'(rdy1), 128'(1));

        // Reset in WAIT drops the read
        req_valid = 1'b1; req_hwrite = 1'b0; req_addr = 32'h10;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 128'(req_ready), 128'(0));
        chk("mid_rst_valid", 128'(rsp_valid), 128'(0));
        chk("mid_rst_data", rsp_line, 128'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mid_rst_hold%0d", i), 128'(rsp_valid), 128'(0));
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst_novalid%0d", i), 128'(rsp_valid), 128'(0));
        end

        // After reset: 2 writes, then a previously written line reads zero
        do_write(32'h20, '1);
        do_write(32'h21, '1);
        do_read("post_rst_rd10", 32'h10, '0);
`ifdef LLC_MEM_RSP_STATS_EN
        chk("stats_wr", 128'(wr_cnt), 128'(2));
        chk("stats_rd", 128'(rd_cnt), 128'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
